gray_decoder: RTL and testbench
===============================

# gray_decoder

Receive-side companion to the team's Gray code counters. Samples a Gray-coded bus from another clock domain, synchronizes it, and decodes it to binary. Classifies each change as a single step up, a single step down, or an illegal jump, and keeps a signed position accumulator and a saturating error count. Typical uses are async-FIFO pointer monitoring and quadrature/absolute-encoder position tracking.

## Interface
- WIDTH, 4: Gray/binary code width (≥2)
- SYNC_STAGES, 2: synchronizer flop depth (≥2)
- POS_W, 16: position accumulator width (two's complement)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- gray_in  input  WIDTH  Gray code from foreign domain; asynchronous to clk
- clear  input  1  synchronous clear of position and err_count
- binary  output  WIDTH  registered decoded value
- valid  output  1  high once the first decoded sample has been loaded
- step_up  output  1  one-cycle pulse: decoded value advanced by +1 (mod 2^WIDTH)
- step_down  output  1  one-cycle pulse: decoded value moved by −1 (mod 2^WIDTH)
- wrap  output  1  one-cycle pulse: step crossed max→0 (up) or 0→max (down)
- error  output  1  one-cycle pulse: change of magnitude other than ±1
- position  output  POS_W  signed step accumulator
- err_count  output  8  count of error pulses, saturates at 255

## Operation
- Sync chain: SYNC_STAGES flops on gray_in. All stages reset to 0. Only the last stage, g, is decoded.
- Decode (combinational from g): d[WIDTH-1] = g[WIDTH-1]; d[i] = d[i+1] ^ g[i].
- Priming: a fill counter counts SYNC_STAGES+1 edges after reset deasserts. On the final counted edge:
  - binary <= d and valid <= 1.
  - No pulses are asserted, and position and err_count are untouched.
- Tracking (valid=1, every edge):
  - Compute diff = (d − binary) mod 2^WIDTH, then binary <= d.
  - diff=0: no pulses.
  - diff=1: step_up=1, position += 1. wrap=1 if the old binary was all ones.
  - diff=2^WIDTH−1: step_down=1, position −= 1. wrap=1 if the old binary was 0.
  - Any other diff: error=1, err_count += 1 (holds at 255). Position unchanged. binary still resynchronizes to d.
- Pulse rules: step_up, step_down and error are mutually exclusive. wrap only ever asserts alongside step_up or step_down.
- Position arithmetic: modulo 2^POS_W. +1 from 2^(POS_W−1)−1 wraps to −2^(POS_W−1), with no flag.
- clear=1 on an edge:
  - position <= 0 and err_count <= 0.
  - step_up, step_down, wrap and error are forced 0 for that edge.
  - binary still updates to d, and valid is unaffected.
  - clear has priority over any event on the same edge.
- clear during priming: zeroes position and err_count. Priming proceeds normally.

## Timing
- Reset values (asserted immediately, asynchronously):
  - binary=0, valid=0, all pulses=0, position=0, err_count=0.
  - Sync chain=0, fill counter=0.
- Reset mid-operation: all state is discarded and priming restarts from zero.
- Latency: a stable change on gray_in is reflected in binary and the pulses SYNC_STAGES+1 rising edges later (3 at default).
- Pulses are registered and last exactly one clk cycle. Back-to-back steps on consecutive cycles give back-to-back pulses.
- Multi-bit skew on gray_in: a transient mix of old and new values is either a legal ±1 neighbour or flagged as error. Stimulus changing by one Gray bit at a time never produces an error.
- valid stays high until reset.

## Test plan
- Reset release with WIDTH=4, gray_in=0110 held: all outputs stay 0 through edges 1–2. On edge 3: valid=1, binary=0100, no pulses, position=0.
- Forward walk: prime at gray 0000, then step gray_in through codes for 1..15 and back to 0, one code every 4 cycles.
  - Required: 16 step_up pulses and exactly one wrap, coinciding with binary 1111→0000.
  - Final state: position=16, err_count=0.
- Reverse walk from binary 0 through 15 down to 0:
  - Required: 16 step_down pulses, with wrap on the first step (0→1111).
  - Final state: position=−16 (0xFFF0).
- Illegal jump: gray 0000→0011 (binary 0→2).
  - Required: one error pulse, err_count=1, binary=0010, position unchanged.
  - Repeat 300 alternating 0↔2 jumps: err_count=255 and stays there.
- clear asserted on the same edge as a legal +1 step from position=5, err_count=3:
  - That edge: position=0, err_count=0, step_up=0, binary updated.
  - The next step gives position=1.
- Async reset mid-walk (position=7):
  - Outputs go to 0 without waiting for a clk edge.
  - After release, valid returns on edge 3 with binary equal to the current decoded gray_in.

Source files
------------

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - Gray bus synchronizer, decoder and step tracker
// Decodes a synchronized Gray bus and classifies each change as +1, -1 or an illegal jump.
module gray_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   gray_in,
  input  logic               clear,
  output logic [WIDTH-1:0]   binary,
  output logic               valid,
  output logic               step_up,
  output logic               step_down,
  output logic               wrap,
  output logic               error,
  output logic [POS_W-1:0]   position,
  output logic [7:0]         err_count
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
  localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  g;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  diff;
  logic [FILL_W-1:0] fill;

  logic [FILL_W-1:0] fill_n;
  logic [WIDTH-1:0]  binary_n;
  logic              valid_n;
  logic              step_up_n;
  logic              step_down_n;
  logic              wrap_n;
  logic              error_n;
  logic [POS_W-1:0]  position_n;
  logic [7:0]        err_count_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g = sync_q[SYNC_STAGES-1];

  // Running XOR from the MSB down turns Gray into binary.
  always_comb begin
    logic acc;
    acc = 1'b0;
    d   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      d[i] = acc;
    end
  end

  assign diff = d - binary;

  always_comb begin
    fill_n      = fill;
    binary_n    = binary;
    valid_n     = valid;
    step_up_n   = 1'b0;
    step_down_n = 1'b0;
    wrap_n      = 1'b0;
    error_n     = 1'b0;
    position_n  = position;
    err_count_n = err_count;

    if (!valid) begin
      // Wait for the synchronizer to fill before trusting g as a reference.
      if (fill == FILL_LAST) begin
        binary_n = d;
        valid_n  = 1'b1;
      end else begin
        fill_n = fill + FILL_W'(1);
      end
    end else begin
      binary_n = d;
      if (diff == WIDTH'(0)) begin
        step_up_n = 1'b0;
      end else if (diff == WIDTH'(1)) begin
        step_up_n  = 1'b1;
        wrap_n     = (binary == ALL_ONES);
        position_n = position + POS_W'(1);
      end else if (diff == ALL_ONES) begin
        step_down_n = 1'b1;
        wrap_n      = (binary == '0);
        position_n  = position - POS_W'(1);
      end else begin
        error_n = 1'b1;
        if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
      end
    end

    if (clear) begin
      step_up_n   = 1'b0;
      step_down_n = 1'b0;
      wrap_n      = 1'b0;
      error_n     = 1'b0;
      position_n  = '0;
      err_count_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill      <= '0;
      binary    <= '0;
      valid     <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      wrap      <= 1'b0;
      error     <= 1'b0;
      position  <= '0;
      err_count <= '0;
    end else begin
      fill      <= fill_n;
      binary    <= binary_n;
      valid     <= valid_n;
      step_up   <= step_up_n;
      step_down <= step_down_n;
      wrap      <= wrap_n;
      error     <= error_n;
      position  <= position_n;
      err_count <= err_count_n;
    end
  end

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - directed self-checking bench for gray_decoder
module tb_gray_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  gray_in;
  logic        clear;
  logic [3:0]  binary;
  logic        valid;
  logic        step_up;
  logic        step_down;
  logic        wrap;
  logic        error;
  logic [15:0] position;
  logic [7:0]  err_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int n_up, n_dn, n_err, n_wrap, n_bad, wrap_at_dn;
  logic [3:0] wrap_bin;

  gray_decoder #(.WIDTH(4), .SYNC_STAGES(2), .POS_W(16)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .clear(clear),
    .binary(binary), .valid(valid), .step_up(step_up), .step_down(step_down),
    .wrap(wrap), .error(error), .position(position), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_counts();
    n_up = 0; n_dn = 0; n_err = 0; n_wrap = 0; n_bad = 0; wrap_at_dn = -1; wrap_bin = 4'hx;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step_up) n_up++;
      if (step_down) n_dn++;
      if (error) n_err++;
      if ((int'(step_up) + int'(step_down) + int'(error)) > 1) n_bad++;
      if (wrap && !(step_up || step_down)) n_bad++;
      if (wrap) begin
        n_wrap++;
        wrap_bin = binary;
        wrap_at_dn = n_dn;
      end
    end
  endtask

  task automatic restart(input logic [3:0] g);
    gray_in = g;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    clr_counts();
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    gray_in = 4'b0110;
    clr_counts();
    cyc(2);
    check("in_reset_valid", valid, 0);
    reset = 1'b0;

    cyc(1);
    check("prime_e1_valid", valid, 0);
    check("prime_e1_binary", binary, 0);
    cyc(1);
    check("prime_e2_valid", valid, 0);
    check("prime_e2_binary", binary, 0);
    cyc(1);
    check("prime_e3_valid", valid, 1);
    check("prime_e3_binary", binary, 4'b0100);
    check("prime_e3_pulses", {step_up, step_down, wrap, error}, 0);
    check("prime_e3_position", position, 0);

    // Forward walk with latency check on the first step
    restart(4'b0000);
    gray_in = to_gray(1);
    cyc(2);
    check("lat_e2_binary", binary, 0);
    cyc(1);
    check("lat_e3_binary", binary, 1);
    check("lat_e3_step_up", step_up, 1);
    cyc(1);
    check("lat_pulse_one_cycle", step_up, 0);
    for (int b = 2; b <= 16; b++) begin
      gray_in = to_gray(b % 16);
      cyc(4);
    end
    check("fwd_up_count", n_up, 16);
    check("fwd_wrap_count", n_wrap, 1);
    check("fwd_wrap_binary", wrap_bin, 0);
    check("fwd_position", position, 16);
    check("fwd_err_count", err_count, 0);
    check("fwd_bad_pulses", n_bad, 0);

    // Reverse walk
    restart(4'b0000);
    for (int k = 1; k <= 16; k++) begin
      gray_in = to_gray((16 - k) % 16);
      cyc(4);
    end
    check("rev_down_count", n_dn, 16);
    check("rev_wrap_count", n_wrap, 1);
    check("rev_wrap_first", wrap_at_dn, 1);
    check("rev_position", position, 16'hFFF0);
    check("rev_binary", binary, 0);
    check("rev_bad_pulses", n_bad, 0);

    // Illegal jumps and saturation
    clr_counts();
    gray_in = 4'b0011;
    cyc(4);
    check("jump_err_pulses", n_err, 1);
    check("jump_err_count", err_count, 1);
    check("jump_binary", binary, 4'b0010);
    check("jump_position", position, 16'hFFF0);
    for (int j = 0; j < 300; j++) begin
      gray_in = (j % 2 == 0) ? 4'b0000 : 4'b0011;
      cyc(4);
    end
    check("sat_err_pulses", n_err, 301);
    check("sat_err_count", err_count, 255);
    gray_in = 4'b0000;
    cyc(4);
    check("sat_hold", err_count, 255);
    check("sat_bad_pulses", n_bad, 0);

    // Clear coinciding with a legal step
    restart(4'b0000);
    gray_in = to_gray(2); cyc(4);
    gray_in = to_gray(0); cyc(4);
    gray_in = to_gray(2); cyc(4);
    for (int b = 3; b <= 7; b++) begin
      gray_in = to_gray(b);
      cyc(4);
    end
    check("pre_clear_position", position, 5);
    check("pre_clear_err_count", err_count, 3);
    gray_in = to_gray(8);
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_position", position, 0);
    check("clear_err_count", err_count, 0);
    check("clear_step_up", step_up, 0);
    check("clear_binary", binary, 8);
    cyc(1);
    gray_in = to_gray(9);
    cyc(4);
    check("post_clear_position", position, 1);

    // Async reset mid-walk
    for (int b = 10; b <= 15; b++) begin
      gray_in = to_gray(b);
      cyc(4);
    end
    check("mid_position", position, 7);
    #2;
    reset = 1'b1;
    #1;
    check("async_binary", binary, 0);
    check("async_valid", valid, 0);
    check("async_position", position, 0);
    check("async_err_count", err_count, 0);
    gray_in = to_gray(5);
    @(negedge clk);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    check("rst2_e2_valid", valid, 0);
    cyc(1);
    check("rst2_e3_valid", valid, 1);
    check("rst2_e3_binary", binary, 5);
    check("rst2_e3_position", position, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
